// File: rtl/masked_mem_rdwr_arbiter.sv
// -----------------------------------------------------------------------------
// masked_mem_rdwr_arbiter
//
// Shares one masked-memory controller between a read-request NoC stream and a
// write-request NoC stream. Whole messages are granted at a time: the header,
// then the body flits it announces. The two sources alternate round-robin.
// A new grant is only made while the controller reports idle, so read and
// write transactions never overlap inside the memory.
//
// Flits are passed straight through with no buffering. The only added latency
// is the single arbitration cycle (IDLE->HDR) at the start of each message.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rd_req_val/data/rdy           read-request source stream
//   wr_req_val/data/rdy           write-request source stream
//   arb_ctrl_val/data, ctrl_arb_rdy  flit stream into the controller
//   ctrl_busy                     controller has a transaction in progress
//   grant_rd, grant_wr            registered ownership flags (one-hot or zero)
// -----------------------------------------------------------------------------
module masked_mem_rdwr_arbiter #(
    parameter int NOC_DATA_W = 512,
    parameter int MSG_LEN_HI = 29,
    parameter int MSG_LEN_LO = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req_val,
    input  logic [NOC_DATA_W-1:0] rd_req_data,
    output logic                  rd_req_rdy,
    input  logic                  wr_req_val,
    input  logic [NOC_DATA_W-1:0] wr_req_data,
    output logic                  wr_req_rdy,
    output logic                  arb_ctrl_val,
    output logic [NOC_DATA_W-1:0] arb_ctrl_data,
    input  logic                  ctrl_arb_rdy,
    input  logic                  ctrl_busy,
    output logic                  grant_rd,
    output logic                  grant_wr
);

    localparam int LEN_W = MSG_LEN_HI - MSG_LEN_LO + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HDR   = 2'd1;
    localparam logic [1:0] ST_BODY  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             win_wr_q, win_wr_d;   // 1: write source owns the controller
    logic             ptr_wr_q, ptr_wr_d;   // 1: write source wins the next tie
    logic [LEN_W-1:0] cnt_q, cnt_d;         // body flits still to pass
    logic             grant_rd_q, grant_rd_d;
    logic             grant_wr_q, grant_wr_d;

    logic             passing;
    logic             src_val;
    logic             hs;
    logic             pick_wr;
    logic [LEN_W-1:0] hdr_len;

    // Flit path: the owner's stream is wired straight to the controller while
    // the message is in flight; everything else sees rdy=0.
    assign passing       = (state_q == ST_HDR) || (state_q == ST_BODY);
    assign src_val       = win_wr_q ? wr_req_val : rd_req_val;
    assign arb_ctrl_val  = passing & src_val;
    assign arb_ctrl_data = win_wr_q ? wr_req_data : rd_req_data;
    assign rd_req_rdy    = passing & ~win_wr_q & ctrl_arb_rdy;
    assign wr_req_rdy    = passing &  win_wr_q & ctrl_arb_rdy;
    assign hs            = arb_ctrl_val & ctrl_arb_rdy;
    assign hdr_len       = arb_ctrl_data[MSG_LEN_HI:MSG_LEN_LO];

    // With both sources requesting the pointer decides; otherwise the only
    // requester wins.
    assign pick_wr = (rd_req_val && wr_req_val) ? ptr_wr_q : wr_req_val;

    assign grant_rd = grant_rd_q;
    assign grant_wr = grant_wr_q;

    always_comb begin
        state_d    = state_q;
        win_wr_d   = win_wr_q;
        ptr_wr_d   = ptr_wr_q;
        cnt_d      = cnt_q;
        grant_rd_d = grant_rd_q;
        grant_wr_d = grant_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (!ctrl_busy && (rd_req_val || wr_req_val)) begin
                    win_wr_d   = pick_wr;
                    // The source just served goes to the back of the line.
                    ptr_wr_d   = ~pick_wr;
                    grant_rd_d = ~pick_wr;
                    grant_wr_d = pick_wr;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (hs) begin
                    cnt_d   = hdr_len;
                    state_d = (hdr_len == '0) ? ST_DRAIN : ST_BODY;
                end
            end
            ST_BODY: begin
                if (hs) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // At least one cycle here: the controller raises busy one
                // cycle after it accepts the last flit.
                if (!ctrl_busy) begin
                    grant_rd_d = 1'b0;
                    grant_wr_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            win_wr_q   <= 1'b0;
            ptr_wr_q   <= 1'b0;
            cnt_q      <= '0;
            grant_rd_q <= 1'b0;
            grant_wr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_wr_q   <= win_wr_d;
            ptr_wr_q   <= ptr_wr_d;
            cnt_q      <= cnt_d;
            grant_rd_q <= grant_rd_d;
            grant_wr_q <= grant_wr_d;
        end
    end

endmodule

// File: tb/tb_masked_mem_rdwr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_masked_mem_rdwr_arbiter
//
// Each source holds a queue of whole messages. A message-level reference model
// tracks who owns the controller, how many flits of that message are still
// owed and the round-robin preference. Every cycle the DUT's control outputs
// and the passed-through flit are compared against that model.
// -----------------------------------------------------------------------------
module tb_masked_mem_rdwr_arbiter;

    localparam int W  = 512;
    localparam int HI = 29;
    localparam int LO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_req_val, wr_req_val, rd_req_rdy, wr_req_rdy;
    logic [W-1:0] rd_req_data, wr_req_data, arb_ctrl_data;
    logic         arb_ctrl_val, ctrl_arb_rdy, ctrl_busy, grant_rd, grant_wr;

    always #5 clk = ~clk;

    masked_mem_rdwr_arbiter #(
        .NOC_DATA_W (W),
        .MSG_LEN_HI (HI),
        .MSG_LEN_LO (LO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_req_val    (rd_req_val),
        .rd_req_data   (rd_req_data),
        .rd_req_rdy    (rd_req_rdy),
        .wr_req_val    (wr_req_val),
        .wr_req_data   (wr_req_data),
        .wr_req_rdy    (wr_req_rdy),
        .arb_ctrl_val  (arb_ctrl_val),
        .arb_ctrl_data (arb_ctrl_data),
        .ctrl_arb_rdy  (ctrl_arb_rdy),
        .ctrl_busy     (ctrl_busy),
        .grant_rd      (grant_rd),
        .grant_wr      (grant_wr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Pending flits and message lengths per source.
    logic [W-1:0] rd_q[$];
    logic [W-1:0] wr_q[$];
    int           rd_len[$];
    int           wr_len[$];

    // Reference model: owner 0 none / 1 rd / 2 wr; left = flits still owed;
    // ptr = source favoured on a tie.
    int owner, left, total, ptr, delivered;

    // Stimulus knobs.
    int rdy_mode;   // 0 always ready, 1 toggle, 2 random
    int busy_mode;  // 0 idle, 1 random
    int busy_hold;
    bit stall_en;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_flit();
        logic [W-1:0] f;
        for (int i = 0; i < W / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    task automatic push_msg(input int src, input int len);
        logic [W-1:0] f;
        f = rand_flit();
        f[HI:LO] = (HI - LO + 1)'(len);
        if (src == 1) begin
            rd_q.push_back(f);
            rd_len.push_back(len);
            for (int i = 0; i < len; i++) rd_q.push_back(rand_flit());
        end else begin
            wr_q.push_back(f);
            wr_len.push_back(len);
            for (int i = 0; i < len; i++) wr_q.push_back(rand_flit());
        end
    endtask

    task automatic drive();
        case (rdy_mode)
            0:       ctrl_arb_rdy = 1'b1;
            1:       ctrl_arb_rdy = ~ctrl_arb_rdy;
            default: ctrl_arb_rdy = 1'($urandom_range(0, 1));
        endcase
        if (busy_hold > 0) begin
            ctrl_busy = 1'b1;
            busy_hold--;
        end else begin
            ctrl_busy = (busy_mode != 0) && ($urandom_range(0, 2) == 0);
        end
        rd_req_val  = (rd_q.size() > 0) && !(stall_en && $urandom_range(0, 4) == 0);
        rd_req_data = (rd_q.size() > 0) ? rd_q[0] : '0;
        wr_req_val  = (wr_q.size() > 0) && !(stall_en && $urandom_range(0, 4) == 0);
        wr_req_data = (wr_q.size() > 0) ? wr_q[0] : '0;
    endtask

    // One clock: compare at negedge, advance the model at posedge, then drive.
    task automatic step();
        logic         sv, act;
        logic [W-1:0] sd;
        logic [4:0]   exp_ctl, obs_ctl;
        @(negedge clk);
        cyc++;
        act = (owner != 0) && (left > 0);
        sv  = (owner == 2) ? wr_req_val : rd_req_val;
        sd  = (owner == 2) ? wr_req_data : rd_req_data;
        exp_ctl = {act && sv, act && owner == 1 && ctrl_arb_rdy, act && owner == 2 && ctrl_arb_rdy,
                   owner == 1, owner == 2};
        obs_ctl = {arb_ctrl_val, rd_req_rdy, wr_req_rdy, grant_rd, grant_wr};
        check_eq("ctl{val,rdy_rd,rdy_wr,g_rd,g_wr}", W'(obs_ctl), W'(exp_ctl));
        if (act && sv) check_eq("data", arb_ctrl_data, sd);
        @(posedge clk);
        if (rst) begin
            if (owner != 0 && left > 0) begin
                if (left == total) begin
                    // Header never left: the message is still whole at the source.
                    if (owner == 1) rd_len.push_front(total - 1);
                    else            wr_len.push_front(total - 1);
                end else begin
                    for (int i = 0; i < left; i++) begin
                        if (owner == 1) void'(rd_q.pop_front());
                        else            void'(wr_q.pop_front());
                    end
                end
            end
            owner = 0;
            left  = 0;
            ptr   = 1;
        end else if (owner == 0) begin
            if (!ctrl_busy && (rd_req_val || wr_req_val)) begin
                int win;
                win   = (rd_req_val && wr_req_val) ? ptr : (rd_req_val ? 1 : 2);
                owner = win;
                left  = ((win == 1) ? rd_len.pop_front() : wr_len.pop_front()) + 1;
                total = left;
                ptr   = 3 - win;
                $display("cyc=%0d grant %s len=%0d", cyc, (win == 1) ? "rd" : "wr", total - 1);
            end
        end else if (left > 0) begin
            if (sv && ctrl_arb_rdy) begin
                if (owner == 1) void'(rd_q.pop_front());
                else            void'(wr_q.pop_front());
                left--;
                delivered++;
            end
        end else if (!ctrl_busy) begin
            owner = 0;
        end
        #1;
        drive();
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        while ((rd_q.size() > 0 || wr_q.size() > 0 || owner != 0) && n < max) begin
            step();
            n++;
        end
        check_eq("all_msgs_done", W'(rd_q.size() + wr_q.size() + owner), W'(0));
    endtask

    task automatic wait_owner_left(input int o, input int l, input int max);
        int n = 0;
        while (!(owner == o && left == l) && n < max) begin
            step();
            n++;
        end
        check_eq("wait_reached", W'(n < max), W'(1));
    endtask

    initial begin
        rst = 1'b1;
        rd_req_val = 0; wr_req_val = 0; rd_req_data = '0; wr_req_data = '0;
        ctrl_arb_rdy = 0; ctrl_busy = 0;
        owner = 0; left = 0; total = 0; ptr = 1; delivered = 0;
        rdy_mode = 0; busy_mode = 0; busy_hold = 0; stall_en = 0;

        // Reset state.
        repeat (3) step();
        rst = 1'b0;
        drive();

        // 1: rd only, len 2, controller always ready.
        push_msg(1, 2);
        drive();
        delivered = 0;
        run_until_idle(50);
        check_eq("t1_flits", W'(delivered), W'(3));

        // 2: both valid at reset release; rd first, then wr, then rd again.
        rst = 1'b1;
        push_msg(1, 1);
        push_msg(2, 1);
        drive();
        step();
        rst = 1'b0;
        drive();
        delivered = 0;
        run_until_idle(50);
        check_eq("t2_flits", W'(delivered), W'(4));
        push_msg(1, 1);
        push_msg(2, 1);
        drive();
        run_until_idle(50);

        // 3: busy held 10 cycles after the last flit while wr waits.
        push_msg(1, 1);
        drive();
        wait_owner_left(1, 0, 50);
        push_msg(2, 0);
        busy_hold = 10;
        drive();
        run_until_idle(60);

        // 4: two zero-length writes with a busy controller in between.
        push_msg(2, 0);
        push_msg(2, 0);
        busy_mode = 1;
        drive();
        delivered = 0;
        run_until_idle(80);
        check_eq("t4_flits", W'(delivered), W'(2));
        busy_mode = 0;

        // 5: ready toggling during a len 4 message, wr waiting.
        rdy_mode = 1;
        push_msg(1, 4);
        push_msg(2, 2);
        drive();
        delivered = 0;
        run_until_idle(80);
        check_eq("t5_flits", W'(delivered), W'(8));
        rdy_mode = 0;

        // 6: reset mid-body, then a fresh rd message.
        push_msg(1, 4);
        drive();
        wait_owner_left(1, 2, 50);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive();
        step();
        push_msg(1, 1);
        drive();
        delivered = 0;
        run_until_idle(50);
        check_eq("t6_flits", W'(delivered), W'(2));

        // Longer messages crossing an 8-bit length boundary.
        push_msg(2, 255);
        push_msg(1, 256);
        drive();
        run_until_idle(1200);

        // Random traffic.
        rdy_mode = 2;
        busy_mode = 1;
        stall_en = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) push_msg(1, $urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) push_msg(2, $urandom_range(0, 5));
            drive();
            repeat ($urandom_range(1, 8)) step();
        end
        run_until_idle(5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
